smac_job_ctrl: RTL and testbench

- Job-level sequencer that sits above the SMAC engine and its streamer, in the place the higher-level FSM occupies.
- Accepts a job descriptor: tile count, input words per tile, output words per tile.
- Clears the engine at job start, then for each tile issues one input-stream request and one output-stream request to the streamer.
- Counts the beats actually transferred and signals completion with a one-cycle done pulse. Malformed configurations and stray beats are reported on a sticky error flag.

---
 rtl/smac_job_ctrl.sv | 171 +++++++++++++++++
 tb/tb_smac_job_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/smac_job_ctrl.sv
// Job-level sequencer for the SMAC engine: clears the engine once per job, then
// issues one input and one output stream request per tile and counts the beats.
module smac_job_ctrl #(
  parameter int TW = 8,
  parameter int LW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          start_i,
  input  logic [TW-1:0] n_tiles_i,
  input  logic [LW-1:0] in_len_i,
  input  logic [LW-1:0] out_len_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic          engine_clr_o,
  output logic          in_req_valid_o,
  input  logic          in_req_ready_i,
  output logic [LW-1:0] in_req_len_o,
  output logic          out_req_valid_o,
  input  logic          out_req_ready_i,
  output logic [LW-1:0] out_req_len_o,
  input  logic          in_beat_i,
  input  logic          out_beat_i,
  output logic [TW-1:0] tile_idx_o
);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_REQ, S_RUN, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] n_tiles_q, tile_idx_q;
  logic [LW-1:0] in_len_q, out_len_q, in_cnt_q, out_cnt_q;
  logic          in_sent_q, out_sent_q, err_q;
  logic          in_hs, out_hs, tile_done, last_tile, len_ok;

  assign in_hs     = in_req_valid_o & in_req_ready_i;
  assign out_hs    = out_req_valid_o & out_req_ready_i;
  // Completion looks at registered counters, so it trails the final beat by a cycle.
  assign tile_done = (in_cnt_q == in_len_q) && (out_cnt_q == out_len_q);
  assign last_tile = (tile_idx_q == n_tiles_q - TW'(1));
  assign len_ok    = (in_len_i != '0) && (out_len_i != '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start_i) begin
        if (n_tiles_i == '0) state_d = S_DONE;
        else if (len_ok)     state_d = S_CLR;
      end
      S_CLR:  state_d = S_REQ;
      S_REQ:  if ((in_sent_q | in_hs) && (out_sent_q | out_hs)) state_d = S_RUN;
      S_RUN:  if (tile_done) state_d = last_tile ? S_DONE : S_REQ;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (clear_i) state_d = S_IDLE;
  end

  always_comb begin
    busy_o          = 1'b0;
    done_o          = 1'b0;
    engine_clr_o    = 1'b0;
    in_req_valid_o  = 1'b0;
    out_req_valid_o = 1'b0;
    unique case (state_q)
      S_CLR: begin
        busy_o       = 1'b1;
        engine_clr_o = 1'b1;
      end
      S_REQ: begin
        busy_o          = 1'b1;
        in_req_valid_o  = ~in_sent_q;
        out_req_valid_o = ~out_sent_q;
      end
      S_RUN:  busy_o = 1'b1;
      S_DONE: done_o = 1'b1;
      default: ;
    endcase
  end

  assign err_o         = err_q;
  assign in_req_len_o  = in_len_q;
  assign out_req_len_o = out_len_q;
  assign tile_idx_o    = tile_idx_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      n_tiles_q  <= '0;
      in_len_q   <= '0;
      out_len_q  <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      in_sent_q  <= 1'b0;
      out_sent_q <= 1'b0;
      tile_idx_q <= '0;
      err_q      <= 1'b0;
    end else if (clear_i) begin
      n_tiles_q  <= '0;
      in_len_q   <= '0;
      out_len_q  <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      in_sent_q  <= 1'b0;
      out_sent_q <= 1'b0;
      tile_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          tile_idx_q <= '0;
          if (start_i && (n_tiles_i != '0)) begin
            if (len_ok) begin
              n_tiles_q <= n_tiles_i;
              in_len_q  <= in_len_i;
              out_len_q <= out_len_i;
              err_q     <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
          if (in_beat_i || out_beat_i) err_q <= 1'b1;
        end
        S_CLR: begin
          in_cnt_q   <= '0;
          out_cnt_q  <= '0;
          in_sent_q  <= 1'b0;
          out_sent_q <= 1'b0;
          if (in_beat_i || out_beat_i) err_q <= 1'b1;
        end
        S_REQ, S_RUN: begin
          if (in_hs)  in_sent_q  <= 1'b1;
          if (out_hs) out_sent_q <= 1'b1;
          if (in_beat_i) begin
            if (in_cnt_q == in_len_q) err_q <= 1'b1;
            else                      in_cnt_q <= in_cnt_q + LW'(1);
          end
          if (out_beat_i) begin
            if (out_cnt_q == out_len_q) err_q <= 1'b1;
            else                        out_cnt_q <= out_cnt_q + LW'(1);
          end
          // Advancing to the next tile overrides any count update from this cycle.
          if (state_q == S_RUN && tile_done && !last_tile) begin
            tile_idx_q <= tile_idx_q + TW'(1);
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            in_sent_q  <= 1'b0;
            out_sent_q <= 1'b0;
          end
        end
        S_DONE: begin
          tile_idx_q <= '0;
          if (in_beat_i || out_beat_i) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_smac_job_ctrl.sv
// Directed bench for smac_job_ctrl: single job, stalled multi-tile job, zero and
// malformed configs, beat overflow, soft clear mid-job, async reset, ignored start.
module tb_smac_job_ctrl;
  localparam int TW = 8;
  localparam int LW = 16;

  logic          clk, rst_n, clear, start;
  logic [TW-1:0] n_tiles;
  logic [LW-1:0] in_len, out_len;
  logic          busy, done, err, engine_clr;
  logic          in_req_valid, in_req_ready, out_req_valid, out_req_ready;
  logic [LW-1:0] in_req_len, out_req_len;
  logic          in_beat, out_beat;
  logic [TW-1:0] tile_idx;

  int checks = 0;
  int errors = 0;
  int clr_cnt = 0;
  int done_cnt = 0;
  int clr_snap, done_snap;

  smac_job_ctrl #(.TW(TW), .LW(LW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start),
    .n_tiles_i(n_tiles), .in_len_i(in_len), .out_len_i(out_len),
    .busy_o(busy), .done_o(done), .err_o(err), .engine_clr_o(engine_clr),
    .in_req_valid_o(in_req_valid), .in_req_ready_i(in_req_ready), .in_req_len_o(in_req_len),
    .out_req_valid_o(out_req_valid), .out_req_ready_i(out_req_ready), .out_req_len_o(out_req_len),
    .in_beat_i(in_beat), .out_beat_i(out_beat), .tile_idx_o(tile_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n && engine_clr) clr_cnt++;
    if (rst_n && done)       done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int nt, input int il, input int ol);
    n_tiles = TW'(nt);
    in_len  = LW'(il);
    out_len = LW'(ol);
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; start = 1'b0;
    n_tiles = '0; in_len = '0; out_len = '0;
    in_req_ready = 1'b0; out_req_ready = 1'b0; in_beat = 1'b0; out_beat = 1'b0;
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_clr", engine_clr, 0);
    check("rst_valids", {in_req_valid, out_req_valid}, 0);
    check("rst_lens", {in_req_len, out_req_len}, 0);
    check("rst_tile", tile_idx, 0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // Single tile: 4 input beats, 2 output beats, readies high.
    in_req_ready = 1'b1; out_req_ready = 1'b1;
    done_snap = done_cnt;
    launch(1, 4, 2);
    check("t1_clr", engine_clr, 1);
    check("t1_busy", busy, 1);
    check("t1_valid_in_clr", {in_req_valid, out_req_valid}, 0);
    step();
    check("t1_clr_off", engine_clr, 0);
    check("t1_valids", {in_req_valid, out_req_valid}, 2'b11);
    check("t1_in_len", in_req_len, 4);
    check("t1_out_len", out_req_len, 2);
    step();
    check("t1_valids_drop", {in_req_valid, out_req_valid}, 0);
    in_beat = 1'b1;
    repeat (4) step();
    in_beat = 1'b0; out_beat = 1'b1;
    repeat (2) step();
    out_beat = 1'b0;
    check("t1_no_early_done", done, 0);
    step();
    check("t1_done", done, 1);
    check("t1_done_busy", busy, 0);
    check("t1_err", err, 0);
    step();
    check("t1_done_once", done_cnt - done_snap, 1);

    // Three tiles, input ready held low 5 cycles per tile.
    clr_snap = clr_cnt; done_snap = done_cnt;
    in_req_ready = 1'b0; out_req_ready = 1'b1;
    launch(3, 1, 1);
    for (int t = 0; t < 3; t++) begin
      step();
      check("t2_tile_idx", tile_idx, t);
      for (int i = 0; i < 5; i++) begin
        check("t2_in_valid_held", in_req_valid, 1);
        check("t2_in_len_stable", in_req_len, 1);
        if (i == 1) check("t2_out_valid_drop", out_req_valid, 0);
        step();
      end
      in_req_ready = 1'b1;
      check("t2_in_valid_6th", in_req_valid, 1);
      step();
      in_req_ready = 1'b0;
      check("t2_in_valid_after_hs", in_req_valid, 0);
      check("t2_busy_run", busy, 1);
      in_beat = 1'b1; out_beat = 1'b1;
      step();
      in_beat = 1'b0; out_beat = 1'b0;
    end
    step();
    check("t2_done", done, 1);
    step();
    check("t2_single_clr", clr_cnt - clr_snap, 1);
    check("t2_single_done", done_cnt - done_snap, 1);
    check("t2_tile_idle", tile_idx, 0);

    // Zero tiles: immediate done, no requests, no engine clear.
    clr_snap = clr_cnt;
    in_req_ready = 1'b1;
    launch(0, 3, 3);
    check("t3_zero_done", done, 1);
    check("t3_zero_valids", {in_req_valid, out_req_valid, busy}, 0);
    step();
    check("t3_zero_done_off", done, 0);
    check("t3_zero_no_clr", clr_cnt - clr_snap, 0);

    // Zero input length with two tiles: rejected, error raised, stays idle.
    launch(2, 0, 3);
    check("t3_rej_err", err, 1);
    check("t3_rej_busy", busy, 0);
    step();
    check("t3_rej_busy2", busy, 0);
    check("t3_rej_clr", engine_clr, 0);

    // Overflow: third input beat on a 2-beat tile.
    launch(1, 2, 1);
    check("t4_err_cleared", err, 0);
    step(); step();
    in_beat = 1'b1;
    repeat (2) step();
    check("t4_no_err_yet", err, 0);
    step();
    in_beat = 1'b0;
    check("t4_overflow_err", err, 1);
    out_beat = 1'b1;
    step();
    out_beat = 1'b0;
    step();
    check("t4_done_after_ovf", done, 1);
    step();
    check("t4_err_sticky", err, 1);

    // Soft clear in RUN of tile 1 of 3.
    done_snap = done_cnt;
    launch(3, 1, 1);
    step(); step();
    in_beat = 1'b1; out_beat = 1'b1;
    step();
    in_beat = 1'b0; out_beat = 1'b0;
    step();
    check("t5_tile1", tile_idx, 1);
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("t5_clr_busy", busy, 0);
    check("t5_clr_valids", {in_req_valid, out_req_valid}, 0);
    check("t5_clr_tile", tile_idx, 0);
    check("t5_clr_err", err, 0);
    step();
    check("t5_no_done", done_cnt - done_snap, 0);
    launch(1, 1, 1);
    check("t5_restart_clr", engine_clr, 1);
    step();
    check("t5_restart_valids", {in_req_valid, out_req_valid}, 2'b11);
    step();
    in_beat = 1'b1; out_beat = 1'b1;
    step();
    in_beat = 1'b0; out_beat = 1'b0;
    step();
    check("t5_restart_done", done, 1);
    step();

    // Async reset between edges while requests are pending.
    in_req_ready = 1'b0; out_req_ready = 1'b0;
    launch(1, 1, 1);
    step();
    check("t6_req_valid", in_req_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_valids", {in_req_valid, out_req_valid}, 0);
    check("t6_async_busy", busy, 0);
    check("t6_async_lens", in_req_len, 0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // Start held high while busy must not re-clear the engine.
    clr_snap = clr_cnt;
    in_req_ready = 1'b1; out_req_ready = 1'b1;
    n_tiles = 8'd1; in_len = 16'd2; out_len = 16'd2; start = 1'b1;
    step();
    step();
    check("t6_busy_start_req", engine_clr, 0);
    step();
    check("t6_busy_start_run", engine_clr, 0);
    start = 1'b0;
    in_beat = 1'b1; out_beat = 1'b1;
    repeat (2) step();
    in_beat = 1'b0; out_beat = 1'b0;
    step();
    check("t6_done", done, 1);
    step();
    check("t6_one_clr", clr_cnt - clr_snap, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
